i2c_reg_target: RTL and testbench

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

---
 rtl/i2c_reg_target.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C register-bank target: 7-bit addressed, pointer byte then auto-incrementing
// data bytes for writes; sequential reads from the current pointer.
module i2c_reg_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1110000,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned REG_W      = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              scl,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StDevAddr  = 4'd1,
    StDevAck   = 4'd2,
    StPtr      = 4'd3,
    StPtrAck   = 4'd4,
    StWdata    = 4'd5,
    StWdataAck = 4'd6,
    StRdata    = 4'd7,
    StRdataAck = 4'd8
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                sda_drv_q, sda_drv_d;
  logic                ack_on_q, ack_on_d;
  logic                rack_q, rack_d;
  logic                we_q, we_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_rdn_q, wr_rdn_d;

  logic scl_s1, scl_s2, scl_s3;
  logic sda_s1, sda_s2, sda_s3;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_s3 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_s3 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_s3 <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_s3 <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_s3;
  assign scl_fall  = ~scl_s2 & scl_s3;
  assign start_det = scl_s2 & scl_s3 & sda_s3 & ~sda_s2;
  assign stop_det  = scl_s2 & scl_s3 & ~sda_s3 & sda_s2;
  assign rx_byte   = {shift_q[6:0], sda_s2};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_drv_q <= 1'b0;
      ack_on_q  <= 1'b0;
      rack_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      wr_rdn_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_drv_q <= sda_drv_d;
      ack_on_q  <= ack_on_d;
      rack_q    <= rack_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      wr_rdn_q  <= wr_rdn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_drv_d = sda_drv_q;
    ack_on_d  = ack_on_q;
    rack_d    = rack_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    wr_rdn_d  = wr_rdn_q;

    // Pointer advances the cycle after each write strobe.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (!ena || start_det || stop_det) begin
      state_d   = (ena && start_det) ? StDevAddr : StIdle;
      bit_cnt_d = '0;
      sda_drv_d = 1'b0;
      ack_on_d  = 1'b0;
      rack_d    = 1'b0;
    end else begin
      unique case (state_q)
        StDevAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (state_q == StDevAddr) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d  = StDevAck;
                  wr_rdn_d = ~rx_byte[0];
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                addr_d  = rx_byte[ADDR_W-1:0];
                state_d = StPtrAck;
              end else begin
                wdata_d = rx_byte;
                we_d    = 1'b1;
                state_d = StWdataAck;
              end
            end
          end
        end
        StDevAck, StPtrAck, StWdataAck: begin
          // First falling edge pulls SDA low, the second releases it.
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d  = 1'b1;
              sda_drv_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              sda_drv_d = 1'b0;
              if (state_q == StDevAck && !wr_rdn_q) begin
                shift_d   = rdata;
                sda_drv_d = ~rdata[7];
                state_d   = StRdata;
              end else if (state_q == StDevAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              state_d   = StRdataAck;
            end
          end else if (scl_fall) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_drv_d = ~shift_q[6];
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              rack_d = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              state_d = StIdle;
            end
          end else if (scl_fall) begin
            if (rack_q) begin
              rack_d    = 1'b0;
              shift_d   = rdata;
              sda_drv_d = ~rdata[7];
              state_d   = StRdata;
            end else begin
              sda_drv_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sda_oe = sda_drv_q & ena;
    we     = we_q & ena;
    wr_rdn = wr_rdn_q;
    addr   = addr_q;
    wdata  = wdata_q;
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged host on an open-drain SDA line
// and a register bank returning addr*0x11.
module tb_i2c_reg_target;
  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic       scl;
  logic       sda_host;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_rdn;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;

  assign sda_line = sda_host & ~sda_oe;
  assign rdata    = {addr, addr};

  i2c_reg_target dut (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (ena),
    .scl    (scl),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .wr_rdn (wr_rdn),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         we_cnt = 0;
  int         wide_cnt = 0;
  int         oe_cnt = 0;
  logic       we_prev = 1'b0;
  logic [3:0] log_addr [16];
  logic [7:0] log_data [16];

  always @(negedge clk) begin
    if (we) begin
      log_addr[we_cnt % 16] <= addr;
      log_data[we_cnt % 16] <= wdata;
      we_cnt <= we_cnt + 1;
    end
    if (we && we_prev) wide_cnt <= wide_cnt + 1;
    we_prev <= we;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_host = 1'b1; #Q;
    scl = 1'b1;      #Q;
    sda_host = 1'b0; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic i2c_stop();
    sda_host = 1'b0; #Q;
    scl = 1'b1;      #Q;
    sda_host = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_host = b; #Q;
    scl = 1'b1;   #(2 * Q);
    scl = 1'b0;   #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_host = 1'b1; #Q;
    scl = 1'b1;      #Q;
    ack = sda_line;  #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    b = 8'h00;
    sda_host = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1;
      #Q; b = {b[6:0], sda_line};
      #Q; scl = 1'b0;
      #Q;
    end
    sda_host = nack; #Q;
    scl = 1'b1;      #(2 * Q);
    scl = 1'b0;      #Q;
    sda_host = 1'b1;
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [3:0] exp_addr;
    logic [3:0] exp_final;
  } wr_vec_t;

  wr_vec_t vecs [4];

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] b0, b1;
    int         base, oe_base;

    vecs[0] = '{ptr: 8'h00, data: 8'h3C, exp_addr: 4'h0, exp_final: 4'h1};
    vecs[1] = '{ptr: 8'h07, data: 8'hFF, exp_addr: 4'h7, exp_final: 4'h8};
    vecs[2] = '{ptr: 8'h3F, data: 8'h00, exp_addr: 4'hF, exp_final: 4'h0};
    vecs[3] = '{ptr: 8'hA9, data: 8'h81, exp_addr: 4'h9, exp_final: 4'hA};

    rstb = 1'b0; ena = 1'b1; scl = 1'b1; sda_host = 1'b1;
    #23;
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_we", 32'(we), 0);
    check("rst_wr_rdn", 32'(wr_rdn), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wdata", 32'(wdata), 0);
    rstb = 1'b1;
    #(2 * Q);

    for (int v = 0; v < 4; v++) begin
      base = we_cnt;
      i2c_start();
      write_byte(8'hE0, a0);
      write_byte(vecs[v].ptr, a1);
      write_byte(vecs[v].data, a2);
      i2c_stop();
      #Q;
      check("vec_acks", 32'({a0, a1, a2}), 0);
      check("vec_we_cnt", we_cnt - base, 1);
      check("vec_we_addr", 32'(log_addr[base % 16]), 32'(vecs[v].exp_addr));
      check("vec_we_data", 32'(log_data[base % 16]), 32'(vecs[v].data));
      check("vec_final_addr", 32'(addr), 32'(vecs[v].exp_final));
      check("vec_wr_rdn", 32'(wr_rdn), 1);
    end

    // Two-byte burst write from pointer 3.
    base = we_cnt;
    i2c_start();
    write_byte(8'hE0, a0);
    write_byte(8'h03, a1);
    write_byte(8'hA5, a2);
    write_byte(8'h5A, a3);
    i2c_stop();
    #Q;
    check("burst_acks", 32'({a0, a1, a2, a3}), 0);
    check("burst_we_cnt", we_cnt - base, 2);
    check("burst_we0", 32'({log_addr[base % 16], log_data[base % 16]}), 32'h3A5);
    check("burst_we1", 32'({log_addr[(base + 1) % 16], log_data[(base + 1) % 16]}), 32'h45A);
    check("burst_addr", 32'(addr), 5);

    // Read with no pointer write starts at the retained pointer.
    i2c_start();
    write_byte(8'hE1, a0);
    read_byte(b0, 1'b1);
    i2c_stop();
    #Q;
    check("cur_rd_ack", 32'(a0), 0);
    check("cur_rd_data", 32'(b0), 32'h55);
    check("cur_rd_wr_rdn", 32'(wr_rdn), 0);
    check("cur_rd_addr", 32'(addr), 5);

    // Pointer write, repeated START, two-byte read wrapping 0xF -> 0x0.
    i2c_start();
    write_byte(8'hE0, a0);
    write_byte(8'h0F, a1);
    i2c_start();
    write_byte(8'hE1, a2);
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b1);
    #Q;
    check("rd_acks", 32'({a0, a1, a2}), 0);
    check("rd_byte0", 32'(b0), 32'hFF);
    check("rd_byte1", 32'(b1), 32'h00);
    check("rd_nack_idle", 32'(dut.state_q), 0);
    check("rd_addr_wrap", 32'(addr), 0);
    i2c_stop();

    // Foreign device address.
    oe_base = oe_cnt;
    base = we_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h12, a1);
    i2c_stop();
    #Q;
    check("foreign_nack", 32'({a0, a1}), 3);
    check("foreign_oe", oe_cnt - oe_base, 0);
    check("foreign_we", we_cnt - base, 0);
    check("foreign_idle", 32'(dut.state_q), 0);

    // STOP four bits into a data byte.
    i2c_start();
    write_byte(8'hE0, a0);
    write_byte(8'h02, a1);
    base = we_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop();
    #Q;
    check("abort_acks", 32'({a0, a1}), 0);
    check("abort_we", we_cnt - base, 0);
    check("abort_idle", 32'(dut.state_q), 0);
    check("abort_addr", 32'(addr), 2);

    // Disabled block ignores a valid frame.
    ena = 1'b0;
    oe_base = oe_cnt;
    base = we_cnt;
    i2c_start();
    write_byte(8'hE0, a0);
    write_byte(8'h03, a1);
    write_byte(8'h11, a2);
    i2c_stop();
    #Q;
    ena = 1'b1;
    check("dis_nacks", 32'({a0, a1, a2}), 7);
    check("dis_we", we_cnt - base, 0);
    check("dis_oe", oe_cnt - oe_base, 0);
    check("dis_addr", 32'(addr), 2);

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i >= 5 ? 1'b1 : 1'b0);
    sda_host = 1'b1;
    check("ack_driven", 32'(sda_oe), 1);
    rstb = 1'b0;
    #1;
    check("async_release", 32'(sda_oe), 0);
    #20;
    rstb = 1'b1;
    #Q;
    base = we_cnt;
    i2c_start();
    write_byte(8'hE0, a0);
    write_byte(8'h06, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    #Q;
    check("post_rst_acks", 32'({a0, a1, a2}), 0);
    check("post_rst_we_cnt", we_cnt - base, 1);
    check("post_rst_we", 32'({log_addr[base % 16], log_data[base % 16]}), 32'h677);
    check("post_rst_addr", 32'(addr), 7);

    check("we_single_cycle", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
